// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [7:0] MEM_TIMEOUT     = 8'd255;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; perf counter ports exist only
// when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  modport slave (
    input  RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW, ResultSrcE,
    input  PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_EN
    , output StallCycles, FlushCount
`endif
  );

  modport master (
    output RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW, ResultSrcE,
    output PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MemTimeout
`ifdef HAZARD_PERF_EN
    , input StallCycles, FlushCount
`endif
  );
endinterface

// File: rtl/forward_sel.sv
// Operand bypass select for one execute-stage source register.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Memory-stage result is younger, so it wins over writeback.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && reg_match(rd_m, rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && reg_match(rd_w, rs)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stall, branch flush, memory-wait FSM
// with timeout. Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  hz_state_e  state_r;
  logic [7:0] cnt_r;
  logic       timeout_r;
  logic [1:0] fwd_a_s, fwd_b_s;
  logic       load_use_s, mem_wait_s;
  logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_d_s, flush_e_s;

  forward_sel u_fwd_a (
    .rs(hz.RS1E), .rd_m(hz.RDM), .rd_w(hz.RDW),
    .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_a_s)
  );

  forward_sel u_fwd_b (
    .rs(hz.RS2E), .rd_m(hz.RDM), .rd_w(hz.RDW),
    .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_b_s)
  );

  assign load_use_s = (hz.ResultSrcE == RESULT_SRC_LOAD) &&
                      (reg_match(hz.RDE, hz.RS1D) || reg_match(hz.RDE, hz.RS2D));
  assign mem_wait_s = hz.MemReqM && !hz.MemReadyM;

  // Stall/flush decode; memory wait beats branch flush, which beats load-use.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    if (!rst_n) begin
      stall_f_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_wait_s) begin
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
          end else if (hz.PCSrcE) begin
            {flush_d_s, flush_e_s} = 2'b11;
          end else if (load_use_s) begin
            {stall_f_s, stall_d_s, flush_e_s} = 3'b111;
          end else begin
            flush_d_s = 1'b0;
          end
        end
        MEM_WAIT, ERROR: {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
        default:         {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
      endcase
    end
  end

  // Forwarding stays combinational in every state but is quiet during reset.
  always_comb begin
    if (rst_n) begin
      hz.ForwardAE = fwd_a_s;
      hz.ForwardBE = fwd_b_s;
    end else begin
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
    end
  end

  assign hz.StallF     = stall_f_s;
  assign hz.StallD     = stall_d_s;
  assign hz.StallE     = stall_e_s;
  assign hz.StallM     = stall_m_s;
  assign hz.FlushD     = flush_d_s;
  assign hz.FlushE     = flush_e_s;
  assign hz.MemTimeout = timeout_r;

  // Memory-wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_wait_s) begin
            state_r <= MEM_WAIT;
            cnt_r   <= 8'd1;
          end else begin
            cnt_r   <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (hz.MemReadyM) begin
            state_r <= RUN;
            cnt_r   <= 8'd0;
          end else if (cnt_r == MEM_TIMEOUT) begin
            state_r   <= ERROR;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ERROR: timeout_r <= 1'b1;
        default: begin
          state_r   <= ERROR;
          timeout_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_r, flush_count_r;

  // Free-running perf counters; 32-bit overflow wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      stall_cycles_r <= stall_cycles_r + {31'd0, stall_f_s};
      flush_count_r  <= flush_count_r + {31'd0, flush_e_s};
    end
  end

  assign hz.StallCycles = stall_cycles_r;
  assign hz.FlushCount  = flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // model: consecutive stalled cycles of the current memory access, sticky timeout
  int   streak;
  bit   timed_out;
`ifdef HAZARD_PERF_EN
  int unsigned m_stall, m_flush;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic [4:0] rdw, input logic wm, input logic ww);
    if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] exp_ctrl();
    logic lu, mw;
    lu = (hz.ResultSrcE == 2'b01) && (hz.RDE != 5'd0) &&
         ((hz.RDE == hz.RS1D) || (hz.RDE == hz.RS2D));
    mw = hz.MemReqM && !hz.MemReadyM;
    if (timed_out || streak > 0 || mw) return 6'b111100;
    if (hz.PCSrcE) return 6'b000011;
    if (lu) return 6'b110001;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] got_ctrl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};
  endfunction

  task automatic model_reset();
    streak = 0;
    timed_out = 1'b0;
`ifdef HAZARD_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  task automatic model_edge(input logic [5:0] e);
`ifdef HAZARD_PERF_EN
    if (e[5]) m_stall = m_stall + 1;
    if (e[0]) m_flush = m_flush + 1;
`endif
    if (!timed_out) begin
      if (streak == 0) begin
        if (hz.MemReqM && !hz.MemReadyM) streak = 1;
      end else if (hz.MemReadyM) begin
        streak = 0;
      end else begin
        streak = streak + 1;
        if (streak > 255) timed_out = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    logic [5:0] e;
    e = exp_ctrl();
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    hz.RS1D = 5'd0; hz.RS2D = 5'd0; hz.RS1E = 5'd0; hz.RS2E = 5'd0;
    hz.RDE = 5'd0; hz.RDM = 5'd0; hz.RDW = 5'd0; hz.ResultSrcE = 2'b00;
    hz.PCSrcE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0;
    drive_idle();
    hz.RegWriteM = 1'b1; hz.RDM = 5'd3; hz.RS1E = 5'd3; hz.RS2E = 5'd3;
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      got = {got_ctrl(), hz.ForwardAE, hz.ForwardBE, hz.MemTimeout};
      checks++;
      if (got !== 11'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got=%b exp=%b", k, got, 11'd0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_ctrl() !== 6'b000000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", got_ctrl(), 6'b000000);
    end
  endtask

  task automatic test_forwarding();
    drive_idle();
    hz.RDM = 5'd5; hz.RegWriteM = 1'b1; hz.RDW = 5'd5; hz.RegWriteW = 1'b1; hz.RS1E = 5'd5;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_wins got=%b exp=%b", hz.ForwardAE, 2'b10);
    end
    hz.RDM = 5'd0;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_wb got=%b exp=%b", hz.ForwardAE, 2'b01);
    end
    hz.RS1E = 5'd0; hz.RDW = 5'd0;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0 got=%b exp=%b", hz.ForwardAE, 2'b00);
    end
    hz.RS2E = 5'd9; hz.RDW = 5'd9; hz.RDM = 5'd9; hz.RegWriteM = 1'b0;
    #1;
    checks++;
    if (hz.ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwdb_wb_no_regwrite_m got=%b exp=%b", hz.ForwardBE, 2'b01);
    end
    hz.RegWriteW = 1'b0;
    #1;
    checks++;
    if (hz.ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwdb_none got=%b exp=%b", hz.ForwardBE, 2'b00);
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RDE = 5'd7; hz.RS2D = 5'd7; hz.RS1D = 5'd2;
    #1;
    checks++;
    if (got_ctrl() !== 6'b110001) begin
      errors++; $display("FAIL load_use got=%b exp=%b", got_ctrl(), 6'b110001);
    end
    cycle();
    hz.ResultSrcE = 2'b00;
    #1;
    checks++;
    if (got_ctrl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_release got=%b exp=%b", got_ctrl(), 6'b000000);
    end
    cycle();
  endtask

  task automatic test_branch_over_load();
    drive_idle();
    hz.ResultSrcE = 2'b01; hz.RDE = 5'd7; hz.RS1D = 5'd7; hz.PCSrcE = 1'b1;
    #1;
    checks++;
    if (got_ctrl() !== 6'b000011) begin
      errors++; $display("FAIL branch_over_load got=%b exp=%b", got_ctrl(), 6'b000011);
    end
    cycle();
    drive_idle();
  endtask

  task automatic test_mem_wait();
    int bad;
    bad = 0;
    drive_idle();
    hz.MemReqM = 1'b1;
    hz.ResultSrcE = 2'b01; hz.RDE = 5'd7; hz.RS1D = 5'd7;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) hz.MemReadyM = 1'b1;
      #1;
      checks++;
      if (got_ctrl() !== 6'b111100) begin
        errors++;
        $display("FAIL mem_wait_stall[%0d] got=%b exp=%b", i, got_ctrl(), 6'b111100);
      end
      cycle();
    end
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    #1;
    checks++;
    if (got_ctrl() !== 6'b110001) begin
      errors++; $display("FAIL mem_wait_then_load_use got=%b exp=%b", got_ctrl(), 6'b110001);
    end
    cycle();
    drive_idle();
  endtask

  task automatic test_timeout_ready_wins();
    drive_idle();
    hz.MemReqM = 1'b1;
    for (int i = 0; i < 255; i++) cycle();
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b1111000) begin
      errors++; $display("FAIL ready_at_limit got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b1111000);
    end
    cycle();
    drive_idle();
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b0000000) begin
      errors++; $display("FAIL ready_wins_run got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b0000000);
    end
  endtask

  task automatic test_timeout();
    drive_idle();
    hz.MemReqM = 1'b1;
    for (int i = 0; i < 255; i++) cycle();
    #1;
    checks++;
    if (hz.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got=%b exp=%b", hz.MemTimeout, 1'b0);
    end
    cycle();
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b1111001) begin
      errors++; $display("FAIL timeout_set got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b1111001);
    end
    drive_idle();
    hz.MemReadyM = 1'b1; hz.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b1111001) begin
      errors++; $display("FAIL error_sticky got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b1111001);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b0000000) begin
      errors++; $display("FAIL reset_in_error got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b0000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({got_ctrl(), hz.MemTimeout} !== 7'b0000110) begin
      errors++; $display("FAIL run_after_reset got=%b exp=%b", {got_ctrl(), hz.MemTimeout}, 7'b0000110);
    end
    cycle();
    drive_idle();
  endtask

  task automatic test_random();
    logic [5:0] e;
    logic [1:0] ea, eb;
    for (int i = 0; i < 600; i++) begin
      hz.RS1D = 5'($urandom_range(0, 3)); hz.RS2D = 5'($urandom_range(0, 3));
      hz.RS1E = 5'($urandom_range(0, 3)); hz.RS2E = 5'($urandom_range(0, 3));
      hz.RDE  = 5'($urandom_range(0, 3)); hz.RDM  = 5'($urandom_range(0, 3));
      hz.RDW  = 5'($urandom_range(0, 3));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE    = ($urandom_range(0, 3) == 0);
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemReqM   = ($urandom_range(0, 3) == 0);
      hz.MemReadyM = ($urandom_range(0, 3) != 0);
      #1;
      e  = exp_ctrl();
      ea = exp_fwd(hz.RS1E, hz.RDM, hz.RDW, hz.RegWriteM, hz.RegWriteW);
      eb = exp_fwd(hz.RS2E, hz.RDM, hz.RDW, hz.RegWriteM, hz.RegWriteW);
      checks++;
      if ({got_ctrl(), hz.ForwardAE, hz.ForwardBE, hz.MemTimeout} !== {e, ea, eb, timed_out}) begin
        errors++;
        $display("FAIL random[%0d] got=%b exp=%b", i,
                 {got_ctrl(), hz.ForwardAE, hz.ForwardBE, hz.MemTimeout}, {e, ea, eb, timed_out});
      end
      cycle();
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({hz.StallCycles, hz.FlushCount} !== {m_stall, m_flush}) begin
      errors++;
      $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d", hz.StallCycles, hz.FlushCount, m_stall, m_flush);
    end
`endif
    drive_idle();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    hz.ResultSrcE = 2'b01; hz.RDE = 5'd4; hz.RS1D = 5'd4;
    cycle();
    drive_idle();
    hz.PCSrcE = 1'b1;
    cycle();
    drive_idle();
    cycle();
    #1;
    checks++;
    if (hz.StallCycles !== 32'd1) begin
      errors++; $display("FAIL perf_stall got=%0d exp=%0d", hz.StallCycles, 1);
    end
    checks++;
    if (hz.FlushCount !== 32'd2) begin
      errors++; $display("FAIL perf_flush got=%0d exp=%0d", hz.FlushCount, 2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_load();
    test_mem_wait();
    test_timeout_ready_wins();
    test_timeout();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- RS1D, RS2D  in  5  decode-stage source regs
- RS1E, RS2E, RDE  in  5  execute-stage source/destination regs
- ResultSrcE  in  2  execute result select; 2'b01 = load
- PCSrcE  in  1  branch/jump taken in execute
- RDM, RDW  in  5  memory/writeback destination regs
- RegWriteM, RegWriteW  in  1  memory/writeback write enables
- MemReqM  in  1  data-memory access pending in memory stage
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold fetch/decode/execute/memory registers
- FlushD, FlushE  out  1  synchronous clear of decode/execute registers
- ForwardAE, ForwardBE  out  2  operand A/B source select
- MemTimeout  out  1  sticky memory-timeout flag

Function
REQ-002 The block SHALL compute ForwardAE as 2'b10 if RegWriteM && RDM!=0 && RDM==RS1E, else 2'b01 if RegWriteW && RDW!=0 && RDW==RS1E, else 2'b00; ForwardBE SHALL use RS2E identically; memory-stage match SHALL win.
REQ-003 The block SHALL flag load-use when ResultSrcE==2'b01 && RDE!=0 && (RDE==RS1D || RDE==RS2D).
REQ-004 The block SHALL implement the FSM states RUN, MEM_WAIT and ERROR.
REQ-005 In RUN with MemReqM && !MemReadyM, the block SHALL drive StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0 in that cycle, and SHALL go to MEM_WAIT with wait counter=1.
REQ-006 In MEM_WAIT, the block SHALL hold all four stalls at 1, suppress all flushes, and increment the 8-bit wait counter each cycle.
REQ-007 In MEM_WAIT, MemReadyM=1 SHALL cause a return to RUN next cycle with counter cleared; stalls SHALL still be 1 in the MemReadyM cycle.
REQ-008 In MEM_WAIT, a counter of 255 with MemReadyM=0 SHALL cause entry to ERROR and set MemTimeout; MemReadyM=1 on that same cycle SHALL win and return to RUN.
REQ-009 ERROR SHALL hold all stalls at 1 and MemTimeout at 1 until reset, and SHALL have no other exit.
REQ-010 In RUN with no memory wait, PCSrcE=1 SHALL drive FlushD=FlushE=1 and all stalls 0, overriding a simultaneous load-use.
REQ-011 In RUN with load-use and PCSrcE=0, the block SHALL drive StallF=StallD=1, FlushE=1, StallE=StallM=0 and FlushD=0 for exactly the one load-use cycle.
REQ-012 A memory wait SHALL take priority over branch flush and load-use; a pending branch or load-use SHALL be re-evaluated after the wait ends, since the stage registers are held.
REQ-013 Forwarding outputs SHALL remain combinational in every state.

Reset
REQ-014 While rst_n=0, state SHALL be RUN, the counter 0, MemTimeout 0, and all stall/flush/forward outputs 0, independent of clk.
REQ-015 Reset asserted in MEM_WAIT or ERROR SHALL abort immediately; the first post-reset edge SHALL evaluate from RUN.

Configuration
REQ-016 With HAZARD_PERF_EN defined, the block SHALL add 32-bit outputs StallCycles, counting cycles with StallF=1, and FlushCount, counting cycles with FlushE=1.
REQ-017 The HAZARD_PERF_EN counters SHALL reset to 0 and wrap at 2^32-1 to 0.
REQ-018 Without HAZARD_PERF_EN, neither the counters nor their ports SHALL exist.

Structure
REQ-019 Package hazard_pkg SHALL hold the state enum, FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, RESULT_SRC_LOAD=2'b01 and MEM_TIMEOUT=8'd255.
REQ-020 Sub-module forward_sel SHALL implement REQ-002 for one operand and SHALL be instantiated twice.

Verification
REQ-021 Forwarding: RDM=5, RegWriteM=1, RDW=5, RegWriteW=1, RS1E=5 -> ForwardAE=2'b10; with RDM=0 -> 2'b01; with RS1E=0 and RDW=0 -> 2'b00.
REQ-022 Load-use: ResultSrcE=01, RDE=7, RS2D=7 -> one cycle of StallF=StallD=FlushE=1; the next cycle with ResultSrcE=00 -> all 0.
REQ-023 Branch over load-use: PCSrcE=1 with load-use active -> FlushD=FlushE=1, StallF=StallD=0.
REQ-024 Memory wait: MemReqM=1, MemReadyM=0 for 10 cycles then 1 -> stalls high for 11 cycles, RUN on the 12th, no flush pulse.
REQ-025 Timeout: MemReadyM held 0 -> ERROR after counter reaches 255 with MemTimeout=1; rst_n pulse low mid-ERROR -> immediate return to RUN with MemTimeout=0.
REQ-026 With HAZARD_PERF_EN: one load-use stall plus one branch flush -> StallCycles=1, FlushCount=2.
